reg_wb_queue: RTL and testbench

REG_WB_QUEUE -- requirements
Module: reg_wb_queue

---
 rtl/reg_wb_queue.sv | 138 +++++++++++++
 tb/tb_reg_wb_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_queue.sv
// Register writeback arbiter: ALU results win, queued load results fill idle slots.
// Latency: one cycle from accepted ALU input or queue head to the registered write port.
// Backpressure: mem_ready drops when the load queue is full; no fairness toward the queue.
module reg_wb_queue #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [ADDRESS_WIDTH-1:0]   alu_dest,
    input  logic [DATA_WIDTH-1:0]      alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [ADDRESS_WIDTH-1:0]   mem_dest,
    input  logic [DATA_WIDTH-1:0]      mem_data,
    input  logic [ADDRESS_WIDTH-1:0]   rd_addr1,
    input  logic [ADDRESS_WIDTH-1:0]   rd_addr2,
    output logic                       rd_pending1,
    output logic                       rd_pending2,
    output logic                       rg_wrt_en,
    output logic [ADDRESS_WIDTH-1:0]   rg_wrt_dest,
    output logic [DATA_WIDTH-1:0]      rg_wrt_data,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Load-result queue storage; payload needs no reset, only the valid bits do.
    logic [ADDRESS_WIDTH-1:0] ent_dest_q [DEPTH];
    logic [DATA_WIDTH-1:0]    ent_data_q [DEPTH];
    logic [DEPTH-1:0]         ent_vld_q;

    logic [PTR_W-1:0]         head_q, head_d;
    logic [PTR_W-1:0]         tail_q, tail_d;
    logic [CNT_W-1:0]         count_q, count_d;

    logic                     wen_q, wen_d;
    logic [ADDRESS_WIDTH-1:0] wdest_q, wdest_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;

    logic alu_wr;
    logic push;
    logic pop;

    // Arbitration and next-state: ALU first, else drain the head; dest 0 loads are swallowed.
    always_comb begin
        mem_ready = !rst && (count_q < CNT_W'(DEPTH));
        alu_wr    = alu_valid && (alu_dest != '0);
        push      = mem_valid && mem_ready && (mem_dest != '0);
        pop       = !alu_wr && (count_q != '0);

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wen_d   = 1'b0;
        wdest_d = wdest_q;
        wdata_d = wdata_q;

        if (alu_wr) begin
            wen_d   = 1'b1;
            wdest_d = alu_dest;
            wdata_d = alu_data;
        end else if (pop) begin
            wen_d   = 1'b1;
            wdest_d = ent_dest_q[head_q];
            wdata_d = ent_data_q[head_q];
            head_d  = head_q + PTR_W'(1);
        end

        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state and the registered write port; reset discards everything queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wen_q   <= 1'b0;
            wdest_q <= '0;
            wdata_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wen_q   <= wen_d;
            wdest_q <= wdest_d;
            wdata_q <= wdata_d;
        end
    end

    // Entry valid bits: pop and push never hit the same slot on one edge (empty or full).
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_vld_q <= '0;
        end else begin
            if (pop)  ent_vld_q[head_q] <= 1'b0;
            if (push) ent_vld_q[tail_q] <= 1'b1;
        end
    end

    // Entry payload written at the tail on each real enqueue.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_dest_q[tail_q] <= mem_dest;
            ent_data_q[tail_q] <= mem_data;
        end
    end

    // Hazard lookup: a source is pending while any queued entry or the write port targets it.
    always_comb begin
        rd_pending1 = wen_q && (wdest_q == rd_addr1);
        rd_pending2 = wen_q && (wdest_q == rd_addr2);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld_q[i] && (ent_dest_q[i] == rd_addr1)) rd_pending1 = 1'b1;
            if (ent_vld_q[i] && (ent_dest_q[i] == rd_addr2)) rd_pending2 = 1'b1;
        end
        if (rd_addr1 == '0) rd_pending1 = 1'b0;
        if (rd_addr2 == '0) rd_pending2 = 1'b0;
    end

    assign rg_wrt_en   = wen_q;
    assign rg_wrt_dest = wdest_q;
    assign rg_wrt_data = wdata_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: one task per scenario, inline comparisons.
// Inputs change 1ns after the rising edge; outputs are sampled in that same window.
// Summary line reports error and check counts.
module tb_reg_wb_queue;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_dest;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_dest;
    logic [31:0] mem_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        rd_pending1;
    logic        rd_pending2;
    logic        rg_wrt_en;
    logic [4:0]  rg_wrt_dest;
    logic [31:0] rg_wrt_data;
    logic [2:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    reg_wb_queue #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_pending1(rd_pending1), .rd_pending2(rd_pending2),
        .rg_wrt_en(rg_wrt_en), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; alu_valid = 0; alu_dest = 0; alu_data = 0;
        mem_valid = 0; mem_dest = 0; mem_data = 0; rd_addr1 = 5; rd_addr2 = 3;
        repeat (2) step();
        checks++; if (rg_wrt_en !== 1'b0) begin errors++; $display("FAIL rst_en got=%0d exp=0", rg_wrt_en); end
        checks++; if (rg_wrt_dest !== 5'd0) begin errors++; $display("FAIL rst_dest got=%0d exp=0", rg_wrt_dest); end
        checks++; if (rg_wrt_data !== 32'd0) begin errors++; $display("FAIL rst_data got=%0h exp=0", rg_wrt_data); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset got=%0d exp=0", mem_ready); end
        rst = 1'b0;
        #1;
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got=%0d exp=1", mem_ready); end
        checks++; if (rd_pending1 !== 1'b0 || rd_pending2 !== 1'b0) begin errors++; $display("FAIL rst_pending got=%0d%0d exp=00", rd_pending1, rd_pending2); end
    endtask

    task automatic test_alu();
        alu_valid = 1; alu_dest = 5; alu_data = 32'hAAAA0001;
        step();
        checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'd5 || rg_wrt_data !== 32'hAAAA0001) begin
            errors++; $display("FAIL alu_write got=%0d/%0d/%0h exp=1/5/aaaa0001", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
        alu_valid = 0;
        step();
        checks++; if (rg_wrt_en !== 1'b0 || rg_wrt_dest !== 5'd5 || rg_wrt_data !== 32'hAAAA0001) begin
            errors++; $display("FAIL alu_idle_hold got=%0d/%0d/%0h exp=0/5/aaaa0001", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1; alu_dest = 9; alu_data = 32'h900 + i;
            mem_valid = 1; mem_dest = 5'(i); mem_data = 32'h100 + i;
            #1;
            checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got=%0d exp=1", i, mem_ready); end
            step();
            checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'd9 || rg_wrt_data !== 32'h900 + i) begin
                errors++; $display("FAIL fill_alu[%0d] got=%0d/%0d/%0h exp=1/9/%0h", i, rg_wrt_en, rg_wrt_dest, rg_wrt_data, 32'h900 + i); end
            checks++; if (fifo_count !== 3'(i)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, fifo_count, i); end
        end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0d exp=0", mem_ready); end
        mem_dest = 5; mem_data = 32'h555; alu_data = 32'h9FF;
        step();
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_no_accept got=%0d exp=4", fifo_count); end
        mem_valid = 0; alu_valid = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'(i) || rg_wrt_data !== 32'h100 + i) begin
                errors++; $display("FAIL drain[%0d] got=%0d/%0d/%0h exp=1/%0d/%0h", i, rg_wrt_en, rg_wrt_dest, rg_wrt_data, i, 32'h100 + i); end
            checks++; if (fifo_count !== 3'(4 - i)) begin errors++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, fifo_count, 4 - i); end
        end
        step();
        checks++; if (rg_wrt_en !== 1'b0) begin errors++; $display("FAIL drain_idle got=%0d exp=0", rg_wrt_en); end
    endtask

    task automatic test_pending();
        rd_addr1 = 7; rd_addr2 = 0;
        mem_valid = 1; mem_dest = 7; mem_data = 32'h77;
        #1;
        checks++; if (rd_pending1 !== 1'b0) begin errors++; $display("FAIL pend_before got=%0d exp=0", rd_pending1); end
        step();
        mem_valid = 0;
        checks++; if (rd_pending1 !== 1'b1 || rd_pending2 !== 1'b0 || fifo_count !== 3'd1 || rg_wrt_en !== 1'b0) begin
            errors++; $display("FAIL pend_queued got=%0d%0d/%0d/%0d exp=10/1/0", rd_pending1, rd_pending2, fifo_count, rg_wrt_en); end
        step();
        checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'd7 || rd_pending1 !== 1'b1 || rd_pending2 !== 1'b0) begin
            errors++; $display("FAIL pend_commit got=%0d/%0d/%0d%0d exp=1/7/10", rg_wrt_en, rg_wrt_dest, rd_pending1, rd_pending2); end
        step();
        checks++; if (rg_wrt_en !== 1'b0 || rd_pending1 !== 1'b0 || rd_pending2 !== 1'b0) begin
            errors++; $display("FAIL pend_clear got=%0d/%0d%0d exp=0/00", rg_wrt_en, rd_pending1, rd_pending2); end
    endtask

    task automatic test_zero_dest();
        alu_valid = 1; alu_dest = 0; alu_data = 32'hDEAD;
        mem_valid = 1; mem_dest = 0; mem_data = 32'hBEEF;
        #1;
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got=%0d exp=1", mem_ready); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (rg_wrt_en !== 1'b0 || fifo_count !== 3'd0) begin
                errors++; $display("FAIL zero_dest[%0d] got=%0d/%0d exp=0/0", i, rg_wrt_en, fifo_count); end
        end
        alu_valid = 0; mem_valid = 0;
    endtask

    task automatic test_back_to_back();
        alu_valid = 1; alu_dest = 20; alu_data = 32'h20;
        mem_valid = 1;
        for (int i = 0; i < 2; i++) begin
            mem_dest = 5'(10 + i); mem_data = 32'hB0000000 + 10 + i;
            step();
            checks++; if (fifo_count !== 3'(i + 1)) begin errors++; $display("FAIL b2b_prefill[%0d] got=%0d exp=%0d", i, fifo_count, i + 1); end
        end
        alu_valid = 0;
        for (int j = 0; j < 12; j++) begin
            mem_dest = 5'(12 + j); mem_data = 32'hB0000000 + 12 + j;
            step();
            checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'(10 + j) || rg_wrt_data !== 32'hB0000000 + 10 + j || fifo_count !== 3'd2) begin
                errors++; $display("FAIL b2b[%0d] got=%0d/%0d/%0h/%0d exp=1/%0d/%0h/2", j, rg_wrt_en, rg_wrt_dest, rg_wrt_data, fifo_count, 10 + j, 32'hB0000000 + 10 + j); end
        end
        mem_valid = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'(22 + k) || rg_wrt_data !== 32'hB0000000 + 22 + k || fifo_count !== 3'(1 - k)) begin
                errors++; $display("FAIL b2b_tail[%0d] got=%0d/%0d/%0h/%0d exp=1/%0d/%0h/%0d", k, rg_wrt_en, rg_wrt_dest, rg_wrt_data, fifo_count, 22 + k, 32'hB0000000 + 22 + k, 1 - k); end
        end
        step();
        checks++; if (rg_wrt_en !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%0d exp=0", rg_wrt_en); end
    endtask

    task automatic test_reset_full();
        alu_valid = 1; alu_dest = 9; alu_data = 32'h999;
        mem_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            mem_dest = 5'(i); mem_data = 32'hC00 + i;
            step();
        end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL rf_full got=%0d exp=4", fifo_count); end
        rst = 1; mem_dest = 6;
        #1;
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rf_ready_in_reset got=%0d exp=0", mem_ready); end
        step();
        checks++; if (rg_wrt_en !== 1'b0 || rg_wrt_dest !== 5'd0 || rg_wrt_data !== 32'd0 || fifo_count !== 3'd0) begin
            errors++; $display("FAIL rf_cleared got=%0d/%0d/%0h/%0d exp=0/0/0/0", rg_wrt_en, rg_wrt_dest, rg_wrt_data, fifo_count); end
        rst = 0; alu_valid = 0; mem_valid = 0; rd_addr1 = 1; rd_addr2 = 4;
        #1;
        checks++; if (mem_ready !== 1'b1 || rd_pending1 !== 1'b0 || rd_pending2 !== 1'b0) begin
            errors++; $display("FAIL rf_release got=%0d/%0d%0d exp=1/00", mem_ready, rd_pending1, rd_pending2); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (rg_wrt_en !== 1'b0 || fifo_count !== 3'd0) begin
                errors++; $display("FAIL rf_no_write[%0d] got=%0d/%0d exp=0/0", i, rg_wrt_en, fifo_count); end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_fill_drain();
        test_pending();
        test_zero_dest();
        test_back_to_back();
        test_reset_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
